// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the ID->EX pipeline register.
// Opcodes mirror the RV32I base opcode map.
package riscv_pipe_pkg;

  typedef struct packed {
    logic       pad;
    logic       reg_wr_en;
    logic       pc_rs1_sel;
    logic       imm_rs2_sel;
    logic       jump_branch_sel;
    logic       mem_wr_en;
    logic [1:0] reg_write_ctrl;
  } id_ex_ctrl_t;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_ALT = 2'd1;
  localparam logic [1:0] WB_SEL_MEM = 2'd2;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_R3    = 7'b0110011;

  // What the register does on a given posedge, in priority order.
  typedef enum logic [1:0] {
    ACT_NORMAL = 2'd0,
    ACT_FLUSH  = 2'd1,
    ACT_STALL  = 2'd2,
    ACT_BUBBLE = 2'd3
  } id_ex_act_e;

endpackage

// File: rtl/id_ex_if.sv
// ID-side inputs and EX-side registered outputs of the ID->EX pipeline register.
// Handshake: id_valid qualifies the id_* bundle; ex_valid qualifies ex_*, and ex_ctrl is zero whenever ex_valid is 0.
interface id_ex_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();
  logic                      id_valid;
  logic [6:0]                id_opcode;
  logic [2:0]                id_funct3;
  logic [6:0]                id_funct7;
  logic [REG_AW-1:0]         id_rs1;
  logic [REG_AW-1:0]         id_rs2;
  logic [REG_AW-1:0]         id_rd;
  logic [XLEN-1:0]           id_pc;
  logic [XLEN-1:0]           id_rs1_data;
  logic [XLEN-1:0]           id_rs2_data;
  logic [XLEN-1:0]           id_imm;
  riscv_pipe_pkg::id_ex_ctrl_t id_ctrl;

  logic                      ex_valid;
  logic [6:0]                ex_opcode;
  logic [2:0]                ex_funct3;
  logic [6:0]                ex_funct7;
  logic [REG_AW-1:0]         ex_rs1;
  logic [REG_AW-1:0]         ex_rs2;
  logic [REG_AW-1:0]         ex_rd;
  logic [XLEN-1:0]           ex_pc;
  logic [XLEN-1:0]           ex_rs1_data;
  logic [XLEN-1:0]           ex_rs2_data;
  logic [XLEN-1:0]           ex_imm;
  riscv_pipe_pkg::id_ex_ctrl_t ex_ctrl;

  modport master (
    output id_valid, id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
           id_pc, id_rs1_data, id_rs2_data, id_imm, id_ctrl,
    input  ex_valid, ex_opcode, ex_funct3, ex_funct7, ex_rs1, ex_rs2, ex_rd,
           ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl
  );

  modport slave (
    input  id_valid, id_opcode, id_funct3, id_funct7, id_rs1, id_rs2, id_rd,
           id_pc, id_rs1_data, id_rs2_data, id_imm, id_ctrl,
    output ex_valid, ex_opcode, ex_funct3, ex_funct7, ex_rs1, ex_rs2, ex_rd,
           ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl
  );
endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose rd feeds a source
// register actually read by the instruction in ID.
module load_use_detect
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic [1:0]        ex_wb_sel,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              load_use
);
  logic rs1_used;
  logic rs2_used;
  logic ex_is_load;

  always_comb begin
    rs1_used   = !(id_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    rs2_used   = id_opcode inside {OP_R3, OP_ST, OP_BR};
    // x0 is hardwired zero, so a load targeting it never produces data to wait for.
    ex_is_load = ex_valid && (ex_wb_sel == WB_SEL_MEM) && (ex_rd != '0);
    load_use   = ex_is_load && id_valid &&
                 ((rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd)));
  end
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with load-use bubble insertion, EX stall and flush.
// Define ID_EX_BUBBLE_CNT_EN to add the saturating bubble_cnt output.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus,
  input  logic   ex_stall,
  input  logic   flush,
  output logic   hold_id
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);
  import riscv_pipe_pkg::*;

  logic              ex_valid_q, ex_valid_d;
  id_ex_ctrl_t       ex_ctrl_q, ex_ctrl_d;
  logic [6:0]        ex_opcode_q, ex_opcode_d;
  logic [2:0]        ex_funct3_q, ex_funct3_d;
  logic [6:0]        ex_funct7_q, ex_funct7_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
  logic [XLEN-1:0]   ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0]   ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0]   ex_imm_q, ex_imm_d;

  logic       load_use;
  id_ex_act_e act;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid  (ex_valid_q),
    .ex_wb_sel (ex_ctrl_q.reg_write_ctrl),
    .ex_rd     (ex_rd_q),
    .id_valid  (bus.id_valid),
    .id_opcode (bus.id_opcode),
    .id_rs1    (bus.id_rs1),
    .id_rs2    (bus.id_rs2),
    .load_use  (load_use)
  );

  always_comb begin
    act = ACT_NORMAL;
    if (flush)         act = ACT_FLUSH;
    else if (ex_stall) act = ACT_STALL;
    else if (load_use) act = ACT_BUBBLE;
    hold_id = ex_stall | (load_use & ~flush);
  end

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_opcode_d   = ex_opcode_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7_d   = ex_funct7_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    unique case (act)
      // Flush and bubble only kill valid/ctrl; the stale data is harmless once unqualified.
      ACT_FLUSH, ACT_BUBBLE: begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
      end
      ACT_STALL: ;
      ACT_NORMAL: begin
        ex_valid_d    = bus.id_valid;
        ex_ctrl_d     = bus.id_valid ? bus.id_ctrl : '0;
        ex_opcode_d   = bus.id_opcode;
        ex_funct3_d   = bus.id_funct3;
        ex_funct7_d   = bus.id_funct7;
        ex_rs1_d      = bus.id_rs1;
        ex_rs2_d      = bus.id_rs2;
        ex_rd_d       = bus.id_rd;
        ex_pc_d       = bus.id_pc;
        ex_rs1_data_d = bus.id_rs1_data;
        ex_rs2_data_d = bus.id_rs2_data;
        ex_imm_d      = bus.id_imm;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_opcode_q   <= '0;
      ex_funct3_q   <= '0;
      ex_funct7_q   <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7_q   <= ex_funct7_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_ctrl     = ex_ctrl_q;
  assign bus.ex_opcode   = ex_opcode_q;
  assign bus.ex_funct3   = ex_funct3_q;
  assign bus.ex_funct7   = ex_funct7_q;
  assign bus.ex_rs1      = ex_rs1_q;
  assign bus.ex_rs2      = ex_rs2_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_rs1_data = ex_rs1_data_q;
  assign bus.ex_rs2_data = ex_rs2_data_q;
  assign bus.ex_imm      = ex_imm_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((act == ACT_BUBBLE) && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed + randomized bench for id_ex_pipe_reg against a transaction-level model
// of the instruction held in EX.
module tb_id_ex_pipe_reg;
  import riscv_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ex_stall;
  logic flush;
  logic hold_id;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  id_ex_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_pipe_reg #(.XLEN(32), .REG_AW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ex_stall (ex_stall),
    .flush    (flush),
    .hold_id  (hold_id)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  typedef struct {
    logic        valid;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    id_ex_ctrl_t ctrl;
  } instr_t;

  instr_t          m_ex;
  longint unsigned m_bub;
  int              checks = 0;
  int              errors = 0;

  logic [6:0] op_tab [9] = '{OP_R3, OP_LD, OP_I, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t id_now();
    instr_t t;
    t.valid = bus.id_valid;  t.op = bus.id_opcode; t.f3 = bus.id_funct3; t.f7 = bus.id_funct7;
    t.rs1 = bus.id_rs1;      t.rs2 = bus.id_rs2;   t.rd = bus.id_rd;     t.pc = bus.id_pc;
    t.a = bus.id_rs1_data;   t.b = bus.id_rs2_data; t.imm = bus.id_imm;  t.ctrl = bus.id_ctrl;
    return t;
  endfunction

  // Does the instruction in ID need a value the load in EX has not fetched yet?
  function automatic bit model_hazard(instr_t ex, instr_t id);
    bit reads1, reads2, ex_load;
    reads1  = !(id.op inside {OP_LUI, OP_AUIPC, OP_JAL});
    reads2  = id.op inside {OP_R3, OP_ST, OP_BR};
    ex_load = ex.valid && ex.ctrl.reg_write_ctrl == WB_SEL_MEM && ex.rd != 0;
    return ex_load && id.valid && ((reads1 && id.rs1 == ex.rd) || (reads2 && id.rs2 == ex.rd));
  endfunction

  function automatic id_ex_ctrl_t mk_ctrl(bit wr, logic [1:0] wb);
    id_ex_ctrl_t c;
    c = '0;
    c.reg_wr_en = wr;
    c.reg_write_ctrl = wb;
    return c;
  endfunction

  task automatic set_id(input bit v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] pc, input id_ex_ctrl_t c);
    bus.id_valid = v;   bus.id_opcode = op; bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_pc = pc;     bus.id_ctrl = c;
    bus.id_funct3 = 3'($urandom_range(0, 7));
    bus.id_funct7 = 7'($urandom_range(0, 127));
    bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
  endtask

  task automatic set_random_id();
    set_id(1'($urandom_range(0, 9) != 0), op_tab[$urandom_range(0, 8)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom, id_ex_ctrl_t'(8'($urandom_range(0, 255))));
  endtask

  task automatic compare_ex();
    check("ex_valid", bus.ex_valid, m_ex.valid);
    check("ex_ctrl", bus.ex_ctrl, m_ex.ctrl);
    check("ex_fields", {bus.ex_opcode, bus.ex_funct3, bus.ex_funct7, bus.ex_rs1, bus.ex_rs2, bus.ex_rd},
          {m_ex.op, m_ex.f3, m_ex.f7, m_ex.rs1, m_ex.rs2, m_ex.rd});
    check("ex_pc", bus.ex_pc, m_ex.pc);
    check("ex_ops", {bus.ex_rs1_data, bus.ex_rs2_data}, {m_ex.a, m_ex.b});
    check("ex_imm", bus.ex_imm, m_ex.imm);
`ifdef ID_EX_BUBBLE_CNT_EN
    check("bubble_cnt", bubble_cnt, m_bub);
`endif
  endtask

  // One clock: check hold_id on current inputs, advance the model, then check EX.
  task automatic tick();
    instr_t id;
    bit     hz;
    #1;
    id = id_now();
    hz = model_hazard(m_ex, id);
    if (rst_n) check("hold_id", hold_id, ex_stall | (hz & ~flush));
    @(posedge clk);
    if (!rst_n) begin
      m_ex = '{default: '0};
      m_bub = 0;
    end else if (flush) begin
      m_ex.valid = 1'b0; m_ex.ctrl = '0;
    end else if (ex_stall) begin
      // EX keeps its instruction
    end else if (hz) begin
      m_ex.valid = 1'b0; m_ex.ctrl = '0;
      if (m_bub != 64'hFFFF_FFFF) m_bub++;
    end else begin
      m_ex = id;
      if (!id.valid) m_ex.ctrl = '0;
    end
    #1;
    compare_ex();
  endtask

  initial begin
    m_ex = '{default: '0};
    m_bub = 0;
    rst_n = 1'b0; ex_stall = 1'b0; flush = 1'b0;

    // Reset with a valid instruction presented
    set_id(1'b1, OP_R3, 5'd3, 5'd1, 5'd2, 32'h40, mk_ctrl(1'b1, WB_SEL_ALU));
    tick();
    tick();
    rst_n = 1'b1;

    // ADD x3,x1,x2 at pc 0x10
    set_id(1'b1, OP_R3, 5'd3, 5'd1, 5'd2, 32'h10, mk_ctrl(1'b1, WB_SEL_ALU));
    tick();
    check("add_pc", bus.ex_pc, 32'h10);
    check("add_wr_en", bus.ex_ctrl.reg_wr_en, 1'b1);

    // LW x5 then dependent ADD x6,x5,x1: exactly one bubble
    set_id(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 32'h14, mk_ctrl(1'b1, WB_SEL_MEM));
    tick();
    set_id(1'b1, OP_R3, 5'd6, 5'd5, 5'd1, 32'h18, mk_ctrl(1'b1, WB_SEL_ALU));
    #1;
    check("lu_hold", hold_id, 1'b1);
    tick();
    check("lu_bubble", bus.ex_valid, 1'b0);
    tick();
    check("lu_add_in", {bus.ex_valid, bus.ex_rd}, {1'b1, 5'd6});

    // LW x0 then consumer of x0: no hazard
    set_id(1'b1, OP_LD, 5'd0, 5'd1, 5'd0, 32'h20, mk_ctrl(1'b1, WB_SEL_MEM));
    tick();
    set_id(1'b1, OP_R3, 5'd7, 5'd0, 5'd0, 32'h24, mk_ctrl(1'b1, WB_SEL_ALU));
    tick();
    check("x0_no_bubble", bus.ex_valid, 1'b1);

    // LW x5 then LUI x5 (no source read): no hazard
    set_id(1'b1, OP_LD, 5'd5, 5'd2, 5'd0, 32'h28, mk_ctrl(1'b1, WB_SEL_MEM));
    tick();
    set_id(1'b1, OP_LUI, 5'd5, 5'd5, 5'd5, 32'h2c, mk_ctrl(1'b1, WB_SEL_ALU));
    tick();
    check("lui_no_bubble", bus.ex_pc, 32'h2c);

    // EX stall for three cycles with ID changing
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_random_id();
      tick();
      check("stall_pc_held", bus.ex_pc, 32'h2c);
    end
    ex_stall = 1'b0;

    // Flush together with stall and load-use
    set_id(1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 32'h30, mk_ctrl(1'b1, WB_SEL_MEM));
    tick();
    set_id(1'b1, OP_R3, 5'd6, 5'd5, 5'd5, 32'h34, mk_ctrl(1'b1, WB_SEL_ALU));
    flush = 1'b1; ex_stall = 1'b1;
    tick();
    check("flush_kills", bus.ex_valid, 1'b0);
    flush = 1'b0; ex_stall = 1'b0;

    // Reset mid-stall, then a normal cycle
    set_random_id();
    tick();
    ex_stall = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ex_stall = 1'b0;
    set_id(1'b1, OP_I, 5'd9, 5'd1, 5'd0, 32'h50, mk_ctrl(1'b1, WB_SEL_ALU));
    tick();
    check("post_rst_pc", bus.ex_pc, 32'h50);

    // Randomized traffic with a small register range so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      set_random_id();
      ex_stall = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      rst_n    = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
